ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 195 +++++++++++++++++++
 tb/tb_ex_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative 32-cycle shift-add multiplier for op 11.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_ex_valid,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_write,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_alu_src,
    input  logic        id_ex_branch,
    input  logic        id_ex_jal,
    input  logic        id_ex_jalr,
    input  logic [31:0] id_ex_pc,
    input  logic [31:0] id_ex_rs1_val,
    input  logic [31:0] id_ex_rs2_val,
    input  logic [31:0] id_ex_imm,
    input  logic [4:0]  id_ex_rs1,
    input  logic [4:0]  id_ex_rs2,
    input  logic [4:0]  id_ex_rd,
    input  logic [3:0]  id_ex_alu_op,
    input  logic [2:0]  id_ex_br_funct3,
    input  logic [31:0] mem_wb_result,
    input  logic [4:0]  mem_wb_rd,
    input  logic        mem_wb_reg_write,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_reg2,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_reg_write,
    output logic        ex_mem_mem_write,
    output logic        ex_mem_mem_read,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ex_busy
);

    logic [31:0] res_q, reg2_q;
    logic [4:0]  rd_q;
    logic        rw_q, mw_q, mr_q;

    logic [31:0] fwd_a, fwd_b, op_b, alu_res, ex_res, mul_res;
    logic        br_cond, busy;

    // Loads sitting in EX/MEM have no data yet, so they are not a forwarding source.
    always_comb begin
        fwd_a = id_ex_rs1_val;
        if (id_ex_rs1 != 5'd0 && rw_q && !mr_q && rd_q == id_ex_rs1)
            fwd_a = res_q;
        else if (id_ex_rs1 != 5'd0 && mem_wb_reg_write && mem_wb_rd == id_ex_rs1)
            fwd_a = mem_wb_result;
    end

    always_comb begin
        fwd_b = id_ex_rs2_val;
        if (id_ex_rs2 != 5'd0 && rw_q && !mr_q && rd_q == id_ex_rs2)
            fwd_b = res_q;
        else if (id_ex_rs2 != 5'd0 && mem_wb_reg_write && mem_wb_rd == id_ex_rs2)
            fwd_b = mem_wb_result;
    end

    assign op_b = id_ex_alu_src ? id_ex_imm : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        case (id_ex_alu_op)
            4'd0:    alu_res = fwd_a + op_b;
            4'd1:    alu_res = fwd_a - op_b;
            4'd2:    alu_res = fwd_a & op_b;
            4'd3:    alu_res = fwd_a | op_b;
            4'd4:    alu_res = fwd_a ^ op_b;
            4'd5:    alu_res = fwd_a << op_b[4:0];
            4'd6:    alu_res = fwd_a >> op_b[4:0];
            4'd7:    alu_res = $unsigned($signed(fwd_a) >>> op_b[4:0]);
            4'd8:    alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            4'd9:    alu_res = {31'd0, fwd_a < op_b};
            4'd10:   alu_res = op_b;
            4'd11:   alu_res = mul_res;
            default: alu_res = 32'd0;
        endcase
    end

    assign ex_res = (id_ex_jal || id_ex_jalr) ? id_ex_pc + 32'd4 : alu_res;

    always_comb begin
        br_cond = 1'b0;
        case (id_ex_br_funct3)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a < fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign branch_target = id_ex_jalr ? ((fwd_a + id_ex_imm) & ~32'd1) : id_ex_pc + id_ex_imm;
    assign branch_taken  = ~reset & id_ex_valid & ~busy & ~stall &
                           (id_ex_jal | id_ex_jalr | (id_ex_branch & br_cond));

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
    mul_state_e  state_q, state_d;
    logic [31:0] mcand_q, mplier_q, acc_q;
    logic [4:0]  cnt_q;
    logic        mul_req, busy_raw;

    assign mul_req = id_ex_valid && id_ex_alu_op == 4'd11;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_req) state_d = BUSY;
            BUSY:    if (cnt_q == 5'd31) state_d = DONE;
            DONE:    if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_raw = 1'b0;
        case (state_q)
            IDLE:    busy_raw = mul_req;
            BUSY:    busy_raw = 1'b1;
            default: busy_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
        end else if (state_q == IDLE && mul_req) begin
            mcand_q  <= fwd_a;
            mplier_q <= op_b;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
        end else if (state_q == BUSY) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
        end
    end

    assign busy    = ~reset & busy_raw;
    assign mul_res = acc_q;
`else
    assign busy    = 1'b0;
    assign mul_res = 32'd0;
`endif

    assign ex_busy = busy;

    // A busy cycle inserts a bubble: controls cleared, data fields left as they were.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q  <= 32'd0;
            reg2_q <= 32'd0;
            rd_q   <= 5'd0;
            rw_q   <= 1'b0;
            mw_q   <= 1'b0;
            mr_q   <= 1'b0;
        end else if (!stall) begin
            if (busy) begin
                rw_q <= 1'b0;
                mw_q <= 1'b0;
                mr_q <= 1'b0;
            end else begin
                res_q  <= ex_res;
                reg2_q <= fwd_b;
                rd_q   <= id_ex_rd;
                rw_q   <= id_ex_valid & id_ex_reg_write;
                mw_q   <= id_ex_valid & id_ex_mem_write;
                mr_q   <= id_ex_valid & id_ex_mem_read;
            end
        end
    end

    assign ex_mem_alu_result = res_q;
    assign ex_mem_reg2       = reg2_q;
    assign ex_mem_rd         = rd_q;
    assign ex_mem_reg_write  = rw_q;
    assign ex_mem_mem_write  = mw_q;
    assign ex_mem_mem_read   = mr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random traffic against a spec-level model.
module tb_ex_stage;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
    logic        valid, reg_write, mem_write, mem_read, alu_src, branch, jal, jalr;
    logic [31:0] pc, rs1_val, rs2_val, imm, wb_result;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        wb_rw;
    logic [31:0] o_res, o_reg2, o_tgt;
    logic [4:0]  o_rd;
    logic        o_rw, o_mw, o_mr, o_taken, o_busy;

    int n_cmp = 0, n_err = 0;

    // expected EX/MEM contents
    logic [31:0] m_res = 0, m_reg2 = 0;
    logic [4:0]  m_rd = 0;
    logic        m_rw = 0, m_mw = 0, m_mr = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .id_ex_valid(valid), .id_ex_reg_write(reg_write), .id_ex_mem_write(mem_write),
        .id_ex_mem_read(mem_read), .id_ex_alu_src(alu_src), .id_ex_branch(branch),
        .id_ex_jal(jal), .id_ex_jalr(jalr), .id_ex_pc(pc), .id_ex_rs1_val(rs1_val),
        .id_ex_rs2_val(rs2_val), .id_ex_imm(imm), .id_ex_rs1(rs1), .id_ex_rs2(rs2),
        .id_ex_rd(rd), .id_ex_alu_op(alu_op), .id_ex_br_funct3(funct3),
        .mem_wb_result(wb_result), .mem_wb_rd(wb_rd), .mem_wb_reg_write(wb_rw),
        .ex_mem_alu_result(o_res), .ex_mem_reg2(o_reg2), .ex_mem_rd(o_rd),
        .ex_mem_reg_write(o_rw), .ex_mem_mem_write(o_mw), .ex_mem_mem_read(o_mr),
        .branch_taken(o_taken), .branch_target(o_tgt), .ex_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        valid = 0; reg_write = 0; mem_write = 0; mem_read = 0; alu_src = 0;
        branch = 0; jal = 0; jalr = 0; pc = 0; rs1_val = 0; rs2_val = 0; imm = 0;
        rs1 = 0; rs2 = 0; rd = 0; alu_op = 0; funct3 = 0;
        wb_result = 0; wb_rd = 0; wb_rw = 0; stall = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 0 && m_rw && !m_mr && m_rd == idx) return m_res;
        if (idx != 0 && wb_rw && wb_rd == idx) return wb_result;
        return v;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[4:0];
            6: return a >> b[4:0];
            7: return sa >>> b[4:0];
            8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One non-MUL cycle: check combinational outputs, clock, check the EX/MEM register.
    task automatic step();
        logic [31:0] a, b2, r, t;
        logic tk;
        #1;
        a  = fwd(rs1, rs1_val);
        b2 = fwd(rs2, rs2_val);
        r  = (jal || jalr) ? pc + 4 : alu_ref(alu_op, a, alu_src ? imm : b2);
        t  = jalr ? ((a + imm) & ~32'd1) : pc + imm;
        tk = valid && !stall && (jal || jalr || (branch && cond_ref(funct3, a, b2)));
        chk("busy", o_busy, 0);
        chk("taken", o_taken, tk);
        chk("target", o_tgt, t);
        @(posedge clk);
        if (!stall) begin
            m_res = r; m_reg2 = b2; m_rd = rd;
            m_rw = valid & reg_write; m_mw = valid & mem_write; m_mr = valid & mem_read;
        end
        #1;
        chk("res", o_res, m_res);
        chk("reg2", o_reg2, m_reg2);
        chk("rd", o_rd, m_rd);
        chk("rw", o_rw, m_rw);
        chk("mw", o_mw, m_mw);
        chk("mr", o_mr, m_mr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_res"}, o_res, 0);
        chk({tag, "_reg2"}, o_reg2, 0);
        chk({tag, "_rd"}, o_rd, 0);
        chk({tag, "_rw"}, o_rw, 0);
        chk({tag, "_mw"}, o_mw, 0);
        chk({tag, "_mr"}, o_mr, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_taken"}, o_taken, 0);
    endtask

    initial begin
        logic [31:0] s_res, s_reg2;
        int kind;
        clr();
        valid = 1; jal = 1; alu_op = 11;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        clr();
        reset = 0;
        @(posedge clk); #1;

        // ADD 5+7 into x3, then EX/MEM forwarding beats MEM/WB x3=99
        valid = 1; reg_write = 1; rs1 = 1; rs1_val = 5; rs2 = 2; rs2_val = 7; rd = 3;
        step(); chk("add", o_res, 12);
        rs1 = 3; rs1_val = 0; rs2_val = 1; rd = 4; wb_rd = 3; wb_result = 99; wb_rw = 1;
        step(); chk("fwd_exmem", o_res, 13);
        rd = 6;
        step(); chk("fwd_memwb", o_res, 100);
        // writes to x0 are never forwarded
        rs1 = 1; rs1_val = 5; rs2_val = 7; rd = 0;
        step();
        rs1 = 0; rs1_val = 1; rs2_val = 1; rd = 7; wb_rd = 0;
        step(); chk("fwd_x0", o_res, 2);
        clr(); valid = 1; reg_write = 1; alu_op = 1; rs2_val = 1; rd = 8;
        step(); chk("sub", o_res, 32'hFFFF_FFFF);

        // BLT / BLTU on -1 vs 1, then JALR
        clr(); valid = 1; branch = 1; funct3 = 3'b100; rs1_val = 32'hFFFF_FFFF; rs2_val = 1;
        pc = 32'h100; imm = 32'h40;
        #1 chk("blt_taken", o_taken, 1); chk("blt_tgt", o_tgt, 32'h140);
        step();
        funct3 = 3'b110;
        #1 chk("bltu_taken", o_taken, 0);
        step();
        clr(); valid = 1; jalr = 1; reg_write = 1; rd = 1; rs1_val = 32'h101; imm = 2; pc = 32'h200;
        #1 chk("jalr_tgt", o_tgt, 32'h102);
        step(); chk("jalr_link", o_res, 32'h204);

        // stall holds EX/MEM and suppresses redirect
        s_res = o_res; s_reg2 = o_reg2;
        clr(); valid = 1; jal = 1; reg_write = 1; rd = 9; rs1_val = 3; rs2_val = 4; stall = 1;
        repeat (3) begin
            step();
            chk("stall_taken", o_taken, 0);
            chk("stall_res", o_res, s_res);
            chk("stall_reg2", o_reg2, s_reg2);
        end

`ifdef EX_MUL_EN
        begin
            int busy_cycles;
            logic [63:0] prod;
            busy_cycles = 0;
            prod = 64'h10000 * 64'h10003;
            clr(); valid = 1; reg_write = 1; alu_op = 11; rs1 = 10; rs2 = 11; rd = 5;
            rs1_val = 32'h10000; rs2_val = 32'h10003;
            s_res = o_res;
            for (int k = 0; k < 40; k++) begin
                #1;
                if (!o_busy) break;
                busy_cycles++;
                @(posedge clk); #1;
                chk("mul_bubble_rw", o_rw, 0);
                chk("mul_bubble_res", o_res, s_res);
            end
            chk("mul_busy_cycles", busy_cycles, 33);
            @(posedge clk); #1;
            chk("mul_res", o_res, prod[31:0]);
            chk("mul_res_const", o_res, 32'h0003_0000);
            chk("mul_rw", o_rw, 1);
            chk("mul_rd", o_rd, 5);
            m_res = prod[31:0]; m_reg2 = 32'h10003; m_rd = 5; m_rw = 1; m_mw = 0; m_mr = 0;
            clr();
            step();

            // reset in the middle of BUSY aborts the multiply
            valid = 1; reg_write = 1; alu_op = 11; rd = 12; rs1_val = 7; rs2_val = 9;
            repeat (11) @(posedge clk);
            #1 reset = 1;
            #1 chk_zero("mul_abort");
            clr();
            repeat (2) @(posedge clk);
            #1 reset = 0;
            m_res = 0; m_reg2 = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_mr = 0;
            repeat (40) begin
                @(posedge clk); #1;
                chk("abort_rw", o_rw, 0);
                chk("abort_res", o_res, 0);
            end
        end
`else
        clr(); valid = 1; reg_write = 1; alu_op = 11; rs1_val = 32'h10000; rs2_val = 32'h10003; rd = 5;
        step(); chk("mul_off", o_res, 0);
`endif

        // random traffic; small register indices make forwarding hits frequent
        for (int i = 0; i < 300; i++) begin
            valid = $urandom_range(0, 3) != 0;
            reg_write = $urandom_range(0, 1); mem_write = $urandom_range(0, 1);
            mem_read = $urandom_range(0, 1); alu_src = $urandom_range(0, 1);
            kind = $urandom_range(0, 5);
            branch = (kind == 0); jal = (kind == 1); jalr = (kind == 2);
            funct3 = $urandom_range(0, 7);
            alu_op = $urandom_range(0, 15);
`ifdef EX_MUL_EN
            if (alu_op == 11) alu_op = 0;
`endif
            pc = $urandom; imm = $urandom;
            rs1_val = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            rs2_val = ($urandom_range(0, 3) == 0) ? rs1_val : $urandom;
            rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            wb_rd = $urandom_range(0, 3); wb_result = $urandom; wb_rw = $urandom_range(0, 1);
            stall = $urandom_range(0, 4) == 0;
            step();
        end

        clr(); reset = 1;
        #1 chk_zero("reset_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
